yuv2rgb_csc: RTL and testbench
==============================

# yuv2rgb_csc

Parametrised YCbCr-to-RGB colour-space converter for the video pipeline, placed between the YUV processing chain and the RGB output/display interface. Supports 8- to 12-bit components and four conversion modes: BT.601 limited, BT.709 limited, BT.601 full range and bypass. The mode is switched only at frame boundaries. Syncs are delay-matched to the data path, and outputs are zeroed during blanking.

## Interface
- DW, 8, component width in bits; legal range 8..12.
- clk_i  in  1  pixel clock.
- rst_n_i  in  1  reset, asynchronous, active-low; clock clk_i.
- vs_i  in  1  vertical sync, active-high.
- hs_i  in  1  horizontal sync, active-high.
- de_i  in  1  data enable; the pixel is valid when high.
- y_ch_i  in  DW  luma Y.
- u_ch_i  in  DW  chroma Cb.
- v_ch_i  in  DW  chroma Cr.
- mode_i  in  2  requested mode: 0 = 601 limited, 1 = 709 limited, 2 = 601 full, 3 = bypass.
- vs_o  out  1  vs_i delayed 4 cycles.
- hs_o  out  1  hs_i delayed 4 cycles.
- de_o  out  1  de_i delayed 4 cycles.
- rgb_o  out  3*DW  packed as {R, G, B}.
- mode_o  out  2  mode currently in effect (mode_act).

## Operation
- Offsets scale with width: YO = 16<<(DW-8) and CO = 128<<(DW-8).
- Modes 2 and 3 set the Y offset to 0.
- Coefficients use 8 fractional bits, listed as Ky / Rv / Gu / Gv / Bu:
  - Mode 0: 298 / 409 / 100 / 208 / 516.
  - Mode 1: 298 / 459 / 55 / 136 / 541.
  - Mode 2: 256 / 359 / 88 / 183 / 454.
- Stage 1:
  - Compute signed differences Yd = Y−YO, Ud = U−CO and Vd = V−CO, each DW+1 bits.
  - Latch mode_act into the stage.
- Stage 2: compute the five signed products, each DW+11 bits.
- Stage 3: sum and round, in DW+12 bits signed:
  - R = (Ky·Yd + Rv·Vd + 128) >>> 8.
  - G = (Ky·Yd − Gu·Ud − Gv·Vd + 128) >>> 8.
  - B = (Ky·Yd + Bu·Ud + 128) >>> 8.
- Stage 4: saturate or wrap (see Configuration) and apply blanking.
- Bypass mode: R = V, G = Y, B = U, carried through the same 4 stages.
- Mode latch:
  - vs_d is vs_i registered.
  - On the rising edge of vs_i (vs_i = 1 and vs_d = 0), mode_act <= mode_i.
  - The pixel presented on the edge cycle still uses the old mode.
  - mode_i is ignored at all other times.
- Each stage carries its own mode tag. A mode change therefore never splits a pixel across two coefficient sets.
- Blanking: on every cycle where de_o = 0, rgb_o = 0.
- Data registers load every cycle; the de gating is applied only at the output register.

## Timing
- Fixed latency of 4 clk_i cycles from input to rgb_o, de_o, hs_o and vs_o.
- Throughput is 1 pixel per cycle; there is no backpressure.
- Reset values: rgb_o = 0, vs_o = hs_o = de_o = 0, mode_o = 0, mode_act = 0, and all pipeline stages = 0.
- Reset is asynchronous: the pipeline is flushed immediately.
- After release, the first valid output appears 4 cycles after the first de_i.
- Mode 0 stays in effect until the first vs_i rising edge after reset.
- If vs_i is held high through reset release, no edge is seen until vs_i falls and rises again.
- mode_o updates 1 cycle after the vs_i edge. It describes the input side, not the output.
- de_i may toggle every cycle; each pixel is converted independently.

## Configuration
- CSC_CLAMP_EN defined:
  - The stage 4 result saturates to [0, 2^DW−1].
  - Negative results become 0.
  - Results above 2^DW−1 become 2^DW−1.
- CSC_CLAMP_EN undefined:
  - The stage 4 result is the low DW bits of the stage 3 value (two's-complement wrap), matching legacy converter behaviour.
  - Latency is unchanged.

## Test plan
- Clamp on, DW = 8, mode 0: Y = 235, U = 128, V = 128 -> rgb_o = {255, 255, 255} after exactly 4 cycles. Y = 16, U = 128, V = 128 -> {0, 0, 0}.
- Mode 0, 601 red: Y = 81, U = 90, V = 240 -> {255, 0, 0} with CSC_CLAMP_EN. Without it -> {255, 0, 255}, because B = −1 wraps.
- Overflow: Y = U = V = 255 in mode 0 -> R = 255 with clamp and R = 225 without.
- Mode switch:
  - Drive mode_i = 2 mid-frame: no change.
  - Raise vs_i: the pixel on the edge cycle uses mode 0 and the next pixel uses mode 2.
  - For that next pixel, Y = 128, U = V = 128 -> {128, 128, 128}.
- Bypass (mode 3), DW = 10: Y = 0x155, U = 0x0AA, V = 0x3FF -> {0x3FF, 0x155, 0x0AA}. During de_o = 0, rgb_o = 0, and hs_o/vs_o track the inputs with a 4-cycle delay.
- Assert rst_n_i mid-line while de is high:
  - Outputs go to 0 immediately and mode_o = 0.
  - After release, no spurious de_o occurs before 4 cycles after the first de_i.

Source files
------------

// File: rtl/yuv2rgb_csc.sv
// yuv2rgb_csc: 4-stage YCbCr-to-RGB colour-space converter.
// Modes: 0 = BT.601 limited, 1 = BT.709 limited, 2 = BT.601 full, 3 = bypass.
// Build option CSC_CLAMP_EN: when defined, results saturate to [0, 2^DW-1];
// when undefined, results wrap to the low DW bits (legacy behaviour).
//
// Stream protocol: de_i acts as the valid qualifier of each pixel. There is
// no ready/backpressure; one pixel may be accepted every cycle and de_o marks
// the matching converted pixel exactly 4 cycles later. vs/hs ride along with
// the same delay.
module yuv2rgb_csc #(
  parameter int DW = 8
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            vs_i,
  input  logic            hs_i,
  input  logic            de_i,
  input  logic [DW-1:0]   y_ch_i,
  input  logic [DW-1:0]   u_ch_i,
  input  logic [DW-1:0]   v_ch_i,
  input  logic [1:0]      mode_i,
  output logic            vs_o,
  output logic            hs_o,
  output logic            de_o,
  output logic [3*DW-1:0] rgb_o,
  output logic [1:0]      mode_o
);

  localparam int AW = DW + 1;   // stage 1 difference width
  localparam int PW = DW + 11;  // stage 2 product width
  localparam int SW = DW + 12;  // stage 3 sum width

  localparam logic [1:0] MODE_601L = 2'd0;
  localparam logic [1:0] MODE_709L = 2'd1;
  localparam logic [1:0] MODE_601F = 2'd2;
  localparam logic [1:0] MODE_BYP  = 2'd3;

  localparam logic signed [AW-1:0] Y_OFS = AW'(16 << (DW - 8));
  localparam logic signed [AW-1:0] C_OFS = AW'(128 << (DW - 8));
  localparam logic signed [SW-1:0] RND   = SW'(128);

  // ---------------------------------------------------------------------
  // Mode latch: mode_i is only sampled on a rising edge of vs_i.
  // vs_d resets high so a vs_i held high through reset release is not
  // mistaken for a fresh frame start.
  // ---------------------------------------------------------------------
  logic       vs_d;
  logic [1:0] mode_act;

  // Track vs_i and capture the requested mode at frame start.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vs_d     <= 1'b1;
      mode_act <= MODE_601L;
    end else begin
      vs_d <= vs_i;
      if (vs_i && !vs_d) begin
        mode_act <= mode_i;
      end
    end
  end

  assign mode_o = mode_act;

  // ---------------------------------------------------------------------
  // Stage 1: offset removal. In bypass the raw components are carried
  // zero-extended so the later stages can pass them straight through.
  // ---------------------------------------------------------------------
  logic signed [AW-1:0] y_ext, u_ext, v_ext, y_ofs;
  logic signed [AW-1:0] yd_n, ud_n, vd_n;
  logic signed [AW-1:0] s1_yd, s1_ud, s1_vd;
  logic [1:0]           s1_mode;
  logic                 s1_de, s1_hs, s1_vs;

  // Select Y offset by mode and form the signed differences.
  always_comb begin
    y_ext = $signed({1'b0, y_ch_i});
    u_ext = $signed({1'b0, u_ch_i});
    v_ext = $signed({1'b0, v_ch_i});
    y_ofs = mode_act[1] ? '0 : Y_OFS;
    yd_n  = y_ext;
    ud_n  = u_ext;
    vd_n  = v_ext;
    if (mode_act != MODE_BYP) begin
      yd_n = y_ext - y_ofs;
      ud_n = u_ext - C_OFS;
      vd_n = v_ext - C_OFS;
    end
  end

  // Stage 1 register, tagged with the mode in effect for this pixel.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_yd   <= '0;
      s1_ud   <= '0;
      s1_vd   <= '0;
      s1_mode <= MODE_601L;
      s1_de   <= 1'b0;
      s1_hs   <= 1'b0;
      s1_vs   <= 1'b0;
    end else begin
      s1_yd   <= yd_n;
      s1_ud   <= ud_n;
      s1_vd   <= vd_n;
      s1_mode <= mode_act;
      s1_de   <= de_i;
      s1_hs   <= hs_i;
      s1_vs   <= vs_i;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: five signed products with 8-fractional-bit coefficients.
  // ---------------------------------------------------------------------
  logic signed [PW-1:0] k_y, k_rv, k_gu, k_gv, k_bu;
  logic signed [PW-1:0] y_w, u_w, v_w;
  logic signed [PW-1:0] p_y_n, p_rv_n, p_gu_n, p_gv_n, p_bu_n;
  logic signed [PW-1:0] s2_py, s2_prv, s2_pgu, s2_pgv, s2_pbu;
  logic [1:0]           s2_mode;
  logic                 s2_de, s2_hs, s2_vs;

  // Coefficient set chosen by the stage 1 mode tag.
  always_comb begin
    k_y  = PW'(298);
    k_rv = PW'(409);
    k_gu = PW'(100);
    k_gv = PW'(208);
    k_bu = PW'(516);
    case (s1_mode)
      MODE_709L: begin
        k_y  = PW'(298);
        k_rv = PW'(459);
        k_gu = PW'(55);
        k_gv = PW'(136);
        k_bu = PW'(541);
      end
      MODE_601F: begin
        k_y  = PW'(256);
        k_rv = PW'(359);
        k_gu = PW'(88);
        k_gv = PW'(183);
        k_bu = PW'(454);
      end
      default: ;
    endcase
  end

  // Sign-extend the differences and multiply (bypass passes values through).
  always_comb begin
    y_w    = {{(PW-AW){s1_yd[AW-1]}}, s1_yd};
    u_w    = {{(PW-AW){s1_ud[AW-1]}}, s1_ud};
    v_w    = {{(PW-AW){s1_vd[AW-1]}}, s1_vd};
    p_y_n  = y_w * k_y;
    p_rv_n = v_w * k_rv;
    p_gu_n = u_w * k_gu;
    p_gv_n = v_w * k_gv;
    p_bu_n = u_w * k_bu;
    if (s1_mode == MODE_BYP) begin
      p_y_n  = y_w;
      p_rv_n = v_w;
      p_gu_n = '0;
      p_gv_n = '0;
      p_bu_n = u_w;
    end
  end

  // Stage 2 register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s2_py   <= '0;
      s2_prv  <= '0;
      s2_pgu  <= '0;
      s2_pgv  <= '0;
      s2_pbu  <= '0;
      s2_mode <= MODE_601L;
      s2_de   <= 1'b0;
      s2_hs   <= 1'b0;
      s2_vs   <= 1'b0;
    end else begin
      s2_py   <= p_y_n;
      s2_prv  <= p_rv_n;
      s2_pgu  <= p_gu_n;
      s2_pgv  <= p_gv_n;
      s2_pbu  <= p_bu_n;
      s2_mode <= s1_mode;
      s2_de   <= s1_de;
      s2_hs   <= s1_hs;
      s2_vs   <= s1_vs;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 3: sum, add half an LSB and drop the 8 fractional bits.
  // ---------------------------------------------------------------------
  logic signed [SW-1:0] py_x, prv_x, pgu_x, pgv_x, pbu_x;
  logic signed [SW-1:0] r_sum, g_sum, b_sum;
  logic signed [SW-1:0] r_n, g_n, b_n;
  logic signed [SW-1:0] s3_r, s3_g, s3_b;
  logic                 s3_de, s3_hs, s3_vs;

  // Accumulate the products and round (bypass forwards the raw components).
  always_comb begin
    py_x  = {s2_py[PW-1],  s2_py};
    prv_x = {s2_prv[PW-1], s2_prv};
    pgu_x = {s2_pgu[PW-1], s2_pgu};
    pgv_x = {s2_pgv[PW-1], s2_pgv};
    pbu_x = {s2_pbu[PW-1], s2_pbu};
    r_sum = py_x + prv_x + RND;
    g_sum = py_x - pgu_x - pgv_x + RND;
    b_sum = py_x + pbu_x + RND;
    r_n   = r_sum >>> 8;
    g_n   = g_sum >>> 8;
    b_n   = b_sum >>> 8;
    if (s2_mode == MODE_BYP) begin
      r_n = prv_x;
      g_n = py_x;
      b_n = pbu_x;
    end
  end

  // Stage 3 register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s3_r  <= '0;
      s3_g  <= '0;
      s3_b  <= '0;
      s3_de <= 1'b0;
      s3_hs <= 1'b0;
      s3_vs <= 1'b0;
    end else begin
      s3_r  <= r_n;
      s3_g  <= g_n;
      s3_b  <= b_n;
      s3_de <= s2_de;
      s3_hs <= s2_hs;
      s3_vs <= s2_vs;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 4: range reduction to DW bits, then blanking at the output.
  // ---------------------------------------------------------------------
  logic [DW-1:0] r_o_n, g_o_n, b_o_n;

`ifdef CSC_CLAMP_EN
  localparam logic signed [SW-1:0] MAX_V = SW'((1 << DW) - 1);

  // Saturate each channel into [0, 2^DW-1].
  always_comb begin
    r_o_n = s3_r[DW-1:0];
    g_o_n = s3_g[DW-1:0];
    b_o_n = s3_b[DW-1:0];
    if (s3_r < 0)          r_o_n = '0;
    else if (s3_r > MAX_V) r_o_n = '1;
    if (s3_g < 0)          g_o_n = '0;
    else if (s3_g > MAX_V) g_o_n = '1;
    if (s3_b < 0)          b_o_n = '0;
    else if (s3_b > MAX_V) b_o_n = '1;
  end
`else
  // Only the low DW bits survive a two's-complement wrap.
  logic unused_hi;
  assign unused_hi = ^{s3_r[SW-1:DW], s3_g[SW-1:DW], s3_b[SW-1:DW]};

  // Wrap each channel to its low DW bits.
  always_comb begin
    r_o_n = s3_r[DW-1:0];
    g_o_n = s3_g[DW-1:0];
    b_o_n = s3_b[DW-1:0];
  end
`endif

  // Output register; data is forced to zero whenever de is low.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rgb_o <= '0;
      de_o  <= 1'b0;
      hs_o  <= 1'b0;
      vs_o  <= 1'b0;
    end else begin
      rgb_o <= s3_de ? {r_o_n, g_o_n, b_o_n} : '0;
      de_o  <= s3_de;
      hs_o  <= s3_hs;
      vs_o  <= s3_vs;
    end
  end

endmodule

// File: tb/tb_yuv2rgb_csc.sv
// tb_yuv2rgb_csc: self-checking bench for yuv2rgb_csc. Two instances
// (DW = 8 and DW = 10) share clock, reset, syncs and mode; each has its own
// pixel data. Expected outputs come from an arithmetic reference model and
// are queued with the 4-cycle pipeline delay.
module tb_yuv2rgb_csc;

  localparam int W = 57;  // {vs, hs, de, rgb8[23:0], rgb10[29:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       vs, hs, de;
  logic [1:0] mode;
  logic [7:0] y8, u8, v8;
  logic [9:0] y10, u10, v10;

  logic        vs_o8, hs_o8, de_o8;
  logic [23:0] rgb8;
  logic [1:0]  mode_o8;
  logic        vs_o10, hs_o10, de_o10;
  logic [29:0] rgb10;
  logic [1:0]  mode_o10;

  yuv2rgb_csc #(.DW(8)) dut8 (
    .clk_i(clk), .rst_n_i(rst_n), .vs_i(vs), .hs_i(hs), .de_i(de),
    .y_ch_i(y8), .u_ch_i(u8), .v_ch_i(v8), .mode_i(mode),
    .vs_o(vs_o8), .hs_o(hs_o8), .de_o(de_o8), .rgb_o(rgb8), .mode_o(mode_o8)
  );

  yuv2rgb_csc #(.DW(10)) dut10 (
    .clk_i(clk), .rst_n_i(rst_n), .vs_i(vs), .hs_i(hs), .de_i(de),
    .y_ch_i(y10), .u_ch_i(u10), .v_ch_i(v10), .mode_i(mode),
    .vs_o(vs_o10), .hs_o(hs_o10), .de_o(de_o10), .rgb_o(rgb10), .mode_o(mode_o10)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  int m_mode;   // model of the mode in effect on the input side
  bit m_vs_d;   // model of the previous vs_i sample

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int fmt_val(input int x, input int dw);
    int mx;
    mx = (1 << dw) - 1;
`ifdef CSC_CLAMP_EN
    if (x < 0) return 0;
    if (x > mx) return mx;
    return x;
`else
    return x & mx;
`endif
  endfunction

  function automatic longint ref_rgb(input int dw, input int y, input int u, input int v,
                                     input int md);
    int yo, co, ky, rv, gu, gv, bu, yd, ud, vd, r, g, b;
    if (md == 3) return (longint'(v) << (2 * dw)) | (longint'(y) << dw) | longint'(u);
    case (md)
      1:       begin ky = 298; rv = 459; gu = 55;  gv = 136; bu = 541; end
      2:       begin ky = 256; rv = 359; gu = 88;  gv = 183; bu = 454; end
      default: begin ky = 298; rv = 409; gu = 100; gv = 208; bu = 516; end
    endcase
    yo = (md == 2) ? 0 : (16 << (dw - 8));
    co = 128 << (dw - 8);
    yd = y - yo;
    ud = u - co;
    vd = v - co;
    r = fmt_val((ky * yd + rv * vd + 128) >>> 8, dw);
    g = fmt_val((ky * yd - gu * ud - gv * vd + 128) >>> 8, dw);
    b = fmt_val((ky * yd + bu * ud + 128) >>> 8, dw);
    return (longint'(r) << (2 * dw)) | (longint'(g) << dw) | longint'(b);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back('0);
    m_mode = 0;
    m_vs_d = 1'b1;
  endtask

  task automatic check_outputs(input logic [W-1:0] e);
    check("vs_o8",    64'(vs_o8),    64'(e[56]));
    check("hs_o8",    64'(hs_o8),    64'(e[55]));
    check("de_o8",    64'(de_o8),    64'(e[54]));
    check("rgb8",     64'(rgb8),     64'(e[53:30]));
    check("vs_o10",   64'(vs_o10),   64'(e[56]));
    check("hs_o10",   64'(hs_o10),   64'(e[55]));
    check("de_o10",   64'(de_o10),   64'(e[54]));
    check("rgb10",    64'(rgb10),    64'(e[29:0]));
    check("mode_o8",  64'(mode_o8),  64'(m_mode));
    check("mode_o10", 64'(mode_o10), 64'(m_mode));
  endtask

  // ---------------- driver ----------------
  // Apply one cycle of input, let the edge happen, then check on the
  // falling edge against the entry queued three edges earlier.
  task automatic drive(input bit v_s, input bit h_s, input bit d_e,
                       input int ya, input int ua, input int va,
                       input int yb, input int ub, input int vb, input int md);
    longint r8, r10;
    logic [W-1:0] e;
    vs = v_s; hs = h_s; de = d_e; mode = md[1:0];
    y8 = ya[7:0]; u8 = ua[7:0]; v8 = va[7:0];
    y10 = yb[9:0]; u10 = ub[9:0]; v10 = vb[9:0];
    @(posedge clk);
    r8  = d_e ? ref_rgb(8, ya, ua, va, m_mode) : 0;
    r10 = d_e ? ref_rgb(10, yb, ub, vb, m_mode) : 0;
    e = {v_s, h_s, d_e, 24'(r8), 30'(r10)};
    exp_q.push_back(e);
    if (v_s && !m_vs_d) m_mode = md;
    m_vs_d = v_s;
    @(negedge clk);
    check_outputs(exp_q.pop_front());
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rgb8"},  64'(rgb8),   64'(0));
    check({tag, "_rgb10"}, 64'(rgb10),  64'(0));
    check({tag, "_de"},    64'({de_o8, de_o10, hs_o8, hs_o10, vs_o8, vs_o10}), 64'(0));
    check({tag, "_mode"},  64'({mode_o8, mode_o10}), 64'(0));
  endtask

  function automatic int rnd_c(input int dw);
    int mx;
    mx = (1 << dw) - 1;
    case ($urandom_range(0, 7))
      0:       return 0;
      1:       return mx;
      default: return int'($urandom_range(0, mx));
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    bit rvs, rhs;
    int rmd;
    rst_n = 1'b0;
    vs = 0; hs = 0; de = 0; mode = 0;
    y8 = 0; u8 = 0; v8 = 0; y10 = 0; u10 = 0; v10 = 0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    #2 rst_n = 1'b1;
    model_reset();

    // Idle then mode 0 reference pixels, with blanked cycles in between.
    drive(0, 0, 0, 200, 50, 70, 900, 100, 50, 0);
    drive(0, 0, 1, 235, 128, 128, 940, 512, 512, 0);
    drive(0, 0, 1, 16, 128, 128, 64, 512, 512, 0);
    drive(0, 0, 1, 81, 90, 240, 324, 360, 960, 0);
    drive(0, 1, 0, 99, 99, 99, 500, 500, 500, 0);
    drive(0, 0, 1, 255, 255, 255, 1023, 1023, 1023, 0);
    drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);

    // Mode request mid-frame is ignored; takes effect after the vs edge.
    drive(0, 0, 1, 128, 128, 128, 512, 512, 512, 2);
    drive(0, 0, 1, 128, 128, 128, 512, 512, 512, 2);
    drive(1, 0, 1, 128, 128, 128, 512, 512, 512, 2);
    drive(1, 0, 1, 128, 128, 128, 512, 512, 512, 0);
    drive(0, 0, 1, 255, 0, 255, 1023, 0, 1023, 0);

    // Bypass, with syncs toggling and blanked cycles.
    drive(1, 0, 0, 1, 2, 3, 4, 5, 6, 3);
    drive(1, 1, 1, 8'h55, 8'hAA, 8'hFF, 10'h155, 10'h0AA, 10'h3FF, 3);
    drive(0, 1, 0, 8'h55, 8'hAA, 8'hFF, 10'h155, 10'h0AA, 10'h3FF, 3);
    drive(0, 0, 1, 8'hFF, 8'h00, 8'h80, 10'h3FF, 10'h000, 10'h200, 3);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Randomised frames: syncs toggle occasionally, de every cycle at will.
    rvs = 0; rhs = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) rvs = ~rvs;
      if ($urandom_range(0, 7) == 0) rhs = ~rhs;
      rmd = int'($urandom_range(0, 3));
      drive(rvs, rhs, 1'($urandom_range(0, 1)),
            rnd_c(8), rnd_c(8), rnd_c(8), rnd_c(10), rnd_c(10), rnd_c(10), rmd);
    end

    // Asynchronous reset mid-line with de high and vs held high.
    drive(0, 0, 1, 10, 20, 30, 40, 50, 60, 2);
    drive(1, 0, 1, 81, 90, 240, 324, 360, 960, 2);
    drive(1, 0, 1, 200, 100, 50, 800, 400, 200, 2);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    for (int i = 0; i < 2; i++) begin
      y8 = 8'($urandom_range(0, 255));
      @(posedge clk);
      @(negedge clk);
      check_all_zero("in_rst");
    end
    de = 0; vs = 1; mode = 1;
    #2 rst_n = 1'b1;
    model_reset();
    drive(1, 0, 0, 1, 1, 1, 1, 1, 1, 1);
    drive(1, 0, 0, 1, 1, 1, 1, 1, 1, 1);
    drive(1, 0, 1, 81, 90, 240, 324, 360, 960, 1);
    drive(1, 0, 1, 235, 128, 128, 940, 512, 512, 1);
    drive(0, 0, 1, 180, 60, 200, 700, 300, 800, 1);
    drive(1, 0, 1, 180, 60, 200, 700, 300, 800, 1);
    drive(1, 0, 1, 180, 60, 200, 700, 300, 800, 2);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
